// File: rtl/led_trail_pwm.sv
// led_trail_pwm: drives the board LEDs from the chaser pattern, adding a PWM fade-out trail.
// Latency: pattern_n sampled at edge N reaches led_n at edge N+1; the brightness it sets affects PWM from N+2.
// Backpressure: none; the block takes a new pattern every cycle and never stalls.
//
// Ports:
//   Clock      - system clock, everything is on its rising edge
//   Reset      - synchronous, active-low; clears every register, overrides enable
//   enable     - 1 = run; 0 = blank the LEDs, clear the trail, freeze the counters
//   pattern_n  - 8-bit active-low pattern from the chaser (0 = lit), same clock domain
//   led_n      - 8-bit active-low LED pin drive, registered
//   decay_tick - registered one-cycle pulse on every global decay step
module led_trail_pwm #(
  parameter int PWM_BITS     = 4,
  parameter int DECAY_PERIOD = 1048576
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       enable,
  input  logic [7:0] pattern_n,
  output logic [7:0] led_n,
  output logic       decay_tick
);

  localparam int                  DEC_W    = $clog2(DECAY_PERIOD);
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [DEC_W-1:0]    DEC_ONE  = DEC_W'(1);
  localparam logic [DEC_W-1:0]    DEC_LAST = DEC_W'(DECAY_PERIOD - 1);

  logic [7:0]          r_pat;         // active-high copy of the pattern
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [DEC_W-1:0]    r_dec_cnt;
  logic                r_decay_tick;
  logic [PWM_BITS-1:0] r_b [8];       // per-LED brightness
  logic [7:0]          r_led_n;

  logic                w_dec_wrap;
  logic [PWM_BITS-1:0] w_b_next [8];
  logic [7:0]          w_led_n_next;

  always_comb begin
    w_dec_wrap   = (r_dec_cnt == DEC_LAST);
    w_led_n_next = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      w_b_next[i] = r_b[i];
      // A lit LED reloads to full brightness even on a decay cycle, so a
      // re-lit LED never gets knocked down by a coincident tick.
      if (!enable) begin
        w_b_next[i] = '0;
      end else if (r_pat[i]) begin
        w_b_next[i] = MAX;
      end else if (r_decay_tick && (r_b[i] != '0)) begin
        w_b_next[i] = r_b[i] - PWM_ONE;
      end
      // Lit LEDs bypass the PWM compare so they stay at 100% duty.
      w_led_n_next[i] = ~(enable & (r_pat[i] | (r_b[i] > r_pwm_cnt)));
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_pat        <= '0;
      r_pwm_cnt    <= '0;
      r_dec_cnt    <= '0;
      r_decay_tick <= 1'b0;
      r_led_n      <= 8'hFF;
      for (int i = 0; i < 8; i++) begin
        r_b[i] <= '0;
      end
    end else begin
      r_pat <= ~pattern_n;
      // Counters freeze while disabled and resume from where they stopped.
      if (enable) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
        r_dec_cnt <= w_dec_wrap ? '0 : (r_dec_cnt + DEC_ONE);
      end
      r_decay_tick <= w_dec_wrap & enable;
      r_led_n      <= w_led_n_next;
      for (int i = 0; i < 8; i++) begin
        r_b[i] <= w_b_next[i];
      end
    end
  end

  assign led_n      = r_led_n;
  assign decay_tick = r_decay_tick;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm with PWM_BITS=2 (MAX=3) and DECAY_PERIOD=4.
// Inputs change 1 time unit after a rising edge and outputs are read at the same
// point, so each observation shows the registers updated by that edge.
module tb_led_trail_pwm;

  logic       Clock;
  logic       Reset;
  logic       enable;
  logic [7:0] pattern_n;
  logic [7:0] led_n;
  logic       decay_tick;

  int total;
  int bad;

  led_trail_pwm #(
    .PWM_BITS    (2),
    .DECAY_PERIOD(4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .enable    (enable),
    .pattern_n (pattern_n),
    .led_n     (led_n),
    .decay_tick(decay_tick)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One reset edge; afterwards every register is zero and edge E1 is next.
  task automatic do_reset();
    Reset     = 1'b0;
    enable    = 1'b1;
    pattern_n = 8'hFF;
    tick();
    Reset = 1'b1;
  endtask

  // Reset holds outputs idle; first decay_tick comes 4 edges after release.
  task automatic test_reset();
    Reset     = 1'b0;
    enable    = 1'b1;
    pattern_n = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (led_n !== 8'hFF) begin
        bad++;
        $display("FAIL reset_led c%0d: got %h want ff", k, led_n);
      end
      total++;
      if (decay_tick !== 1'b0) begin
        bad++;
        $display("FAIL reset_tick c%0d: got %b want 0", k, decay_tick);
      end
    end
    Reset     = 1'b1;
    pattern_n = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      logic exp_t;
      tick();
      exp_t = (k == 4);
      total++;
      if (decay_tick !== exp_t) begin
        bad++;
        $display("FAIL first_tick e%0d: got %b want %b", k, decay_tick, exp_t);
      end
      total++;
      if (led_n !== 8'hFF) begin
        bad++;
        $display("FAIL post_reset_led e%0d: got %h want ff", k, led_n);
      end
    end
  endtask

  // LED0 held lit: dark on E1, fully on from E2 onward.
  task automatic test_lit();
    do_reset();
    pattern_n = 8'hFE;
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] exp_led;
      tick();
      exp_led = (k == 1) ? 8'hFF : 8'hFE;
      total++;
      if (led_n !== exp_led) begin
        bad++;
        $display("FAIL lit e%0d: got %h want %h", k, led_n, exp_led);
      end
    end
  endtask

  // Continues from test_lit: release LED0 at E9 and watch it fade over E9..E28.
  task automatic test_fade();
    logic [19:0] v;
    v = 20'b0001_0011_0111_0111_1111;
    pattern_n = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] exp_led;
      tick();
      exp_led    = 8'hFF;
      exp_led[0] = v[19-i];
      total++;
      if (led_n !== exp_led) begin
        bad++;
        $display("FAIL fade e%0d: got %h want %h", i + 9, led_n, exp_led);
      end
    end
  endtask

  // LED3 fades to b=1, then a one-cycle relight lands on a decay edge (E13):
  // the relight must win, leaving b=3 for the following PWM window.
  task automatic test_lit_beats_decay();
    logic [19:0] v;
    v = 20'b1001_0011_0111_0001_0011;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      logic [7:0] exp_led;
      pattern_n = (k <= 2 || k == 12) ? 8'hF7 : 8'hFF;
      tick();
      exp_led    = 8'hFF;
      exp_led[3] = v[20-k];
      total++;
      if (led_n !== exp_led) begin
        bad++;
        $display("FAIL lit_vs_decay e%0d: got %h want %h", k, led_n, exp_led);
      end
    end
  endtask

  // LED5 mid-fade (b=2) when enable drops for E6..E8: blank at once, trail
  // cleared, counters frozen so the next tick comes at E11 rather than E12.
  task automatic test_enable();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      pattern_n = (k <= 2) ? 8'hDF : 8'hFF;
      enable    = !(k >= 6 && k <= 8);
      tick();
      if (k == 5) begin
        total++;
        if (led_n !== 8'hDF) begin
          bad++;
          $display("FAIL en_midfade e%0d: got %h want df", k, led_n);
        end
      end
      if (k >= 6) begin
        total++;
        if (led_n !== 8'hFF) begin
          bad++;
          $display("FAIL en_dark e%0d: got %h want ff", k, led_n);
        end
      end
      if (k >= 6 && k <= 12) begin
        logic exp_t;
        exp_t = (k == 11);
        total++;
        if (decay_tick !== exp_t) begin
          bad++;
          $display("FAIL en_tick e%0d: got %b want %b", k, decay_tick, exp_t);
        end
      end
    end
    enable = 1'b1;
  endtask

  // Chaser sweep, 4 edges per LED. Window E18..E21 has head LED4 with a trail
  // of 3,2,1,0 lit cycles on LEDs 3..0. Reset at E23 kills everything.
  task automatic test_sweep_reset();
    logic [7:0] win [4];
    int         low [5];
    win[0] = 8'hE3;
    win[1] = 8'hE7;
    win[2] = 8'hEF;
    win[3] = 8'hE1;
    for (int i = 0; i < 5; i++) low[i] = 0;
    do_reset();
    for (int k = 1; k <= 27; k++) begin
      pattern_n = (k <= 22) ? ~(8'h01 << ((k - 1) / 4)) : 8'hFF;
      Reset     = (k != 23);
      tick();
      if (k >= 18 && k <= 21) begin
        total++;
        if (led_n !== win[k-18]) begin
          bad++;
          $display("FAIL sweep e%0d: got %h want %h", k, led_n, win[k-18]);
        end
        for (int i = 0; i < 5; i++) begin
          if (led_n[i] == 1'b0) low[i]++;
        end
      end
      if (k == 23) begin
        total++;
        if (decay_tick !== 1'b0) begin
          bad++;
          $display("FAIL sweep_rst_tick: got %b want 0", decay_tick);
        end
      end
      if (k >= 23) begin
        total++;
        if (led_n !== 8'hFF) begin
          bad++;
          $display("FAIL sweep_rst e%0d: got %h want ff", k, led_n);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (low[i] != i) begin
        bad++;
        $display("FAIL trail_duty led%0d: got %0d lit of 4 want %0d", i, low[i], i);
      end
    end
    Reset = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    Reset     = 1'b0;
    enable    = 1'b1;
    pattern_n = 8'hFF;
    test_reset();
    test_lit();
    test_fade();
    test_lit_beats_decay();
    test_enable();
    test_sweep_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
